// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver: parity modes,
// receiver FSM state encoding and oversampling constants.
package uart_pkg;

    // Parity mode of the received frame.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Ticks of mclkx16 per bit and the centre tick of a bit.
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    // Majority of three samples taken around the bit centre.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words {data, parityerr, framingerr}.
// Only built when UART_RX_FIFO_EN is defined; a write while full is accepted
// only when a read happens in the same cycle, otherwise it is dropped.
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB tells full from empty.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`endif

// File: rtl/uart_rx_gen2.sv
// UART receiver, 16x oversampled, with 7/8/9 majority sampling.
// Optional feature: define UART_RX_FIFO_EN to replace the single holding
// register with a FIFO_DEPTH-entry receive FIFO (uart_rx_fifo).
module uart_rx_gen2
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                 mclkx16,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 rxrdy,
    output logic                 parityerr,
    output logic                 framingerr,
    output logic                 overrun
);

    localparam logic [TICK_W-1:0] TICK_FIRST  = TICK_W'(MID_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_MID    = TICK_W'(MID_TICK);
    localparam logic [TICK_W-1:0] TICK_DECIDE = TICK_W'(MID_TICK + 1);
    localparam logic [2:0]        LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0]        LAST_STOP   = 3'(STOP_BITS - 1);
    localparam logic              ODD_PARITY  = (PARITY == PAR_ODD);

    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 deliver_q, deliver_d;
    logic                 decide;
    logic                 maj;
    logic                 overrun_q;

    assign decide = (tick_q == TICK_DECIDE);
    assign maj    = majority3(samp_q[0], samp_q[1], rx_sync_q);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic. Every bit is resolved at tick 9 of its 16-tick cell;
    // the tick counter free-runs across bits so cells stay exactly 16 long.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + TICK_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        deliver_d = 1'b0;
        samp_d    = samp_q;
        if (tick_q == TICK_FIRST) samp_d[0] = rx_sync_q;
        if (tick_q == TICK_MID)   samp_d[1] = rx_sync_q;

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (decide) begin
                    bit_d   = '0;
                    state_d = maj ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    perr_d  = ((^shift_q) ^ maj) != ODD_PARITY;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (!maj) ferr_d = 1'b1;
                    if (bit_q == LAST_STOP) begin
                        bit_d     = '0;
                        deliver_d = 1'b1;
                        state_d   = ferr_d ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                tick_d = '0;
                if (rx_sync_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // FSM, counters and frame accumulation registers.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            deliver_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            deliver_q <= deliver_d;
        end
    end

    assign overrun = overrun_q;

`ifdef UART_RX_FIFO_EN
    localparam int ENTRY_W = DATA_BITS + 2;

    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               full;
    logic               pop;

    assign pop = read & ~empty;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (mclkx16),
        .rst_b_i (reset),
        .push_i  (deliver_q),
        .wdata_i ({shift_q, perr_q, ferr_q}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign rxrdy      = ~empty;
    assign dataout    = empty ? '0 : head[ENTRY_W-1:2];
    assign parityerr  = empty ? 1'b0 : head[1];
    assign framingerr = empty ? 1'b0 : head[0];

    // Sticky overrun: set by a dropped push, cleared by the next pop.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (pop) begin
            overrun_q <= 1'b0;
        end else if (deliver_q && full) begin
            overrun_q <= 1'b1;
        end
    end
`else
    logic [DATA_BITS-1:0] hold_data_q;
    logic                 hold_perr_q;
    logic                 hold_ferr_q;
    logic                 rxrdy_q;
    logic                 unused_fifo_depth;

    assign unused_fifo_depth = |FIFO_DEPTH;

    assign rxrdy      = rxrdy_q;
    assign dataout    = hold_data_q;
    assign parityerr  = hold_perr_q;
    assign framingerr = hold_ferr_q;

    // Holding register: load on delivery when free or being read, clear on
    // read so outputs are zero whenever no word is presented.
    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            hold_data_q <= '0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            rxrdy_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (deliver_q && (!rxrdy_q || read)) begin
                hold_data_q <= shift_q;
                hold_perr_q <= perr_q;
                hold_ferr_q <= ferr_q;
                rxrdy_q     <= 1'b1;
            end else if (read && rxrdy_q) begin
                hold_data_q <= '0;
                hold_perr_q <= 1'b0;
                hold_ferr_q <= 1'b0;
                rxrdy_q     <= 1'b0;
            end
            if (read && rxrdy_q) begin
                overrun_q <= 1'b0;
            end else if (deliver_q && rxrdy_q) begin
                overrun_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Bench for uart_rx_gen2: instance 0 uses defaults (8N1), instance 1 uses
// even parity with two stop bits. Expected words come from a queue model.
module tb_uart_rx_gen2;
    import uart_pkg::*;

    localparam int FD = 4;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = FD;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic [7:0] dout0, dout1;
    logic       rdy0, rdy1, perr0, perr1, ferr0, ferr1, ovr0, ovr1;

    int vectors = 0;
    int errors  = 0;

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    bit         ovr_m0 = 1'b0, ovr_m1 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_gen2 #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(FD)) dut0 (
        .mclkx16(clk), .reset(rst_n), .read(rd0), .rx(rx0), .dataout(dout0),
        .rxrdy(rdy0), .parityerr(perr0), .framingerr(ferr0), .overrun(ovr0));

    uart_rx_gen2 #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(FD)) dut1 (
        .mclkx16(clk), .reset(rst_n), .read(rd1), .rx(rx1), .dataout(dout1),
        .rxrdy(rdy1), .parityerr(perr1), .framingerr(ferr1), .overrun(ovr1));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int i, input logic b);
        if (i == 0) rx0 = b; else rx1 = b;
    endtask

    task automatic model_push(input int i, input logic [9:0] e);
        if (i == 0) begin
            if (q0.size() < CAP) q0.push_back(e); else ovr_m0 = 1'b1;
        end else begin
            if (q1.size() < CAP) q1.push_back(e); else ovr_m1 = 1'b1;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ovr_m0 = 1'b0;
        ovr_m1 = 1'b0;
    endtask

    // Serialise one frame; instance 1 adds a parity bit and a second stop bit.
    task automatic send(input int i, input logic [7:0] d, input logic pbit,
                        input logic s0, input logic s1);
        logic pe, fe;
        set_rx(i, 1'b0);
        cyc(16);
        for (int b = 0; b < 8; b++) begin
            set_rx(i, d[b]);
            cyc(16);
        end
        if (i == 1) begin
            set_rx(i, pbit);
            cyc(16);
        end
        set_rx(i, s0);
        cyc(16);
        if (i == 1) begin
            set_rx(i, s1);
            cyc(16);
        end
        set_rx(i, 1'b1);
        cyc(6);
        pe = (i == 1) ? ((^d) ^ pbit) : 1'b0;
        fe = !s0 || ((i == 1) && !s1);
        model_push(i, {d, pe, fe});
    endtask

    task automatic chk(input int i, input string tag);
        logic [9:0] e;
        logic       has;
        logic       om;
        if (i == 0) begin
            has = (q0.size() != 0);
            e   = has ? q0[0] : 10'd0;
            om  = ovr_m0;
            cmp({tag, ".rdy0"},  {9'd0, rdy0},  {9'd0, has});
            cmp({tag, ".data0"}, {2'd0, dout0}, {2'd0, e[9:2]});
            cmp({tag, ".perr0"}, {9'd0, perr0}, {9'd0, e[1]});
            cmp({tag, ".ferr0"}, {9'd0, ferr0}, {9'd0, e[0]});
            cmp({tag, ".ovr0"},  {9'd0, ovr0},  {9'd0, om});
        end else begin
            has = (q1.size() != 0);
            e   = has ? q1[0] : 10'd0;
            om  = ovr_m1;
            cmp({tag, ".rdy1"},  {9'd0, rdy1},  {9'd0, has});
            cmp({tag, ".data1"}, {2'd0, dout1}, {2'd0, e[9:2]});
            cmp({tag, ".perr1"}, {9'd0, perr1}, {9'd0, e[1]});
            cmp({tag, ".ferr1"}, {9'd0, ferr1}, {9'd0, e[0]});
            cmp({tag, ".ovr1"},  {9'd0, ovr1},  {9'd0, om});
        end
    endtask

    task automatic rd(input int i);
        if (i == 0) begin
            rd0 = 1'b1;
            if (q0.size() != 0) begin
                void'(q0.pop_front());
                ovr_m0 = 1'b0;
            end
        end else begin
            rd1 = 1'b1;
            if (q1.size() != 0) begin
                void'(q1.pop_front());
                ovr_m1 = 1'b0;
            end
        end
        cyc(1);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    initial begin
        int         ri;
        logic [7:0] rdat;
        logic       rp, rs0, rs1;

        // Reset state, during and after reset
        cyc(3);
        chk(0, "rst_hold");
        chk(1, "rst_hold");
        rst_n = 1'b1;
        cyc(5);
        chk(0, "rst_rel");
        chk(1, "rst_rel");

        // Plain 8N1 frame, then a read
        send(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        chk(0, "f5a");
        rd(0);
        chk(0, "f5a_rd");

        // Even parity: 0x03 with parity bit 1 is an error, with 0 it is not
        send(1, 8'h03, 1'b1, 1'b1, 1'b1);
        chk(1, "par1");
        rd(1);
        send(1, 8'h03, 1'b0, 1'b1, 1'b1);
        chk(1, "par0");
        rd(1);
        chk(1, "par_rd");

        // Short low glitch is a false start
        set_rx(0, 1'b0);
        cyc(4);
        set_rx(0, 1'b1);
        cyc(40);
        chk(0, "glitch");
        cmp("glitch.state", 10'(dut0.state_q), 10'(ST_IDLE));
        send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        chk(0, "after_glitch");
        rd(0);

        // Break: line held low for two frame times
        set_rx(0, 1'b0);
        cyc(320);
        model_push(0, {8'h00, 1'b0, 1'b1});
        chk(0, "break");
        rd(0);
        chk(0, "break_rd");
        cyc(200);
        chk(0, "break_hold");
        cmp("break.state", 10'(dut0.state_q), 10'(ST_WAIT_HIGH));
        set_rx(0, 1'b1);
        cyc(40);
        chk(0, "break_end");
        cmp("break_end.state", 10'(dut0.state_q), 10'(ST_IDLE));

        // Two frames without a read
        send(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1, 1'b1);
        chk(0, "ovr2");
        rd(0);
        chk(0, "ovr2_rd");
        for (int k = 0; k < CAP + 1; k++) rd(0);

        // Five frames without a read, then four reads
        for (int v = 1; v <= 5; v++) send(0, 8'(v), 1'b0, 1'b1, 1'b1);
        chk(0, "five");
        for (int k = 0; k < 4; k++) begin
            chk(0, "five_rd");
            rd(0);
        end
        chk(0, "five_end");
        for (int k = 0; k < CAP + 1; k++) rd(0);

        // Randomised frames on both instances
        for (int k = 0; k < 30; k++) begin
            ri   = int'($urandom_range(0, 1));
            rdat = 8'($urandom);
            rp   = 1'($urandom);
            rs0  = ($urandom_range(0, 7) != 0);
            rs1  = ($urandom_range(0, 7) != 0);
            send(ri, rdat, rp, rs0, rs1);
            chk(ri, "rand");
            if ($urandom_range(0, 1) == 1) begin
                rd(ri);
                chk(ri, "rand_rd");
            end
        end
        for (int k = 0; k < CAP + 1; k++) begin
            rd(0);
            rd(1);
        end
        chk(0, "drain");
        chk(1, "drain");

        // Reset pulse in the middle of the data bits
        send(0, 8'h77, 1'b0, 1'b1, 1'b1);
        send(0, 8'h78, 1'b0, 1'b1, 1'b1);
        send(1, 8'h81, 1'b0, 1'b1, 1'b1);
        chk(0, "pre_rst");
        set_rx(0, 1'b0);
        cyc(16);
        set_rx(0, 1'b1);
        cyc(16);
        set_rx(0, 1'b0);
        cyc(16);
        set_rx(0, 1'b1);
        cyc(8);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk(0, "rst_mid");
        chk(1, "rst_mid");
        cmp("rst_mid.state", 10'(dut0.state_q), 10'(ST_IDLE));
        cyc(3);
        rst_n = 1'b1;
        set_rx(0, 1'b1);
        cyc(40);
        chk(0, "rst_quiet");
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        chk(0, "rst_a5");
        rd(0);
        chk(0, "rst_a5_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
